avmm_mem_responder: RTL and testbench

Avalon-MM responder (slave endpoint) terminating the command stream produced by the local-memory pipeline bridge. It backs a small on-chip word array and accepts single and burst reads and writes. It returns read bursts through a configurable read-latency pipeline. It serves as the EMIF-less memory target for subsystem bring-up and bridge loopback testing.

---
 rtl/avmm_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_avmm_mem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_mem_responder.sv
// Avalon-MM memory responder: small on-chip word array serving single/burst
// reads and writes, with read data returned through a fixed-latency pipe.
module avmm_mem_responder #(
  parameter int DATA_WIDTH       = 32,
  parameter int SYMBOL_WIDTH     = 8,
  parameter int HDL_ADDR_WIDTH   = 10,
  parameter int BURSTCOUNT_WIDTH = 4,
  parameter int RESPONSE_WIDTH   = 2,
  parameter int MEM_DEPTH_LOG2   = 6,
  parameter int READ_LATENCY     = 2,
  parameter int BYTEEN_WIDTH     = DATA_WIDTH / SYMBOL_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  output logic                        s0_waitrequest,
  input  logic [HDL_ADDR_WIDTH-1:0]   s0_address,
  input  logic [BURSTCOUNT_WIDTH-1:0] s0_burstcount,
  input  logic                        s0_read,
  input  logic                        s0_write,
  input  logic [DATA_WIDTH-1:0]       s0_writedata,
  input  logic [BYTEEN_WIDTH-1:0]     s0_byteenable,
  output logic [DATA_WIDTH-1:0]       s0_readdata,
  output logic                        s0_readdatavalid,
  output logic [RESPONSE_WIDTH-1:0]   s0_response,
  output logic                        err_protocol
);

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam logic [RESPONSE_WIDTH-1:0] RESP_SLVERR = RESPONSE_WIDTH'(2'b10);
  localparam logic [BURSTCOUNT_WIDTH-1:0] BC_ONE = BURSTCOUNT_WIDTH'(1);
  localparam logic [MEM_DEPTH_LOG2-1:0] ADDR_ONE = MEM_DEPTH_LOG2'(1);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_ISSUE} state_t;

  state_t state, state_next;
  logic [DATA_WIDTH-1:0]       mem [DEPTH];
  logic [MEM_DEPTH_LOG2-1:0]   addr_q, addr_next, mem_waddr;
  logic [BURSTCOUNT_WIDTH-1:0] count_q, count_next, bc_eff;
  logic                        oor_q, oor_next, cmd_oor;
  logic                        wait_next, err_next;
  logic                        accept, mem_we, issue;
  logic [DATA_WIDTH-1:0]       issue_data;

  assign accept  = (s0_read | s0_write) & ~s0_waitrequest;
  assign cmd_oor = (s0_address >> MEM_DEPTH_LOG2) != '0;
  assign bc_eff  = (s0_burstcount == '0) ? BC_ONE : s0_burstcount;

  // count_q holds beats left to write in WR_BURST and beats left to issue in RD_ISSUE
  always_comb begin
    state_next = state;
    addr_next  = addr_q;
    count_next = count_q;
    oor_next   = oor_q;
    wait_next  = 1'b0;
    err_next   = err_protocol;
    mem_we     = 1'b0;
    mem_waddr  = addr_q;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (s0_burstcount == '0) err_next = 1'b1;
          oor_next = cmd_oor;
          if (s0_write) begin
            if (s0_read) err_next = 1'b1;
            mem_we     = ~cmd_oor;
            mem_waddr  = s0_address[MEM_DEPTH_LOG2-1:0];
            addr_next  = s0_address[MEM_DEPTH_LOG2-1:0] + ADDR_ONE;
            count_next = bc_eff - BC_ONE;
            if (bc_eff != BC_ONE) state_next = WR_BURST;
          end else begin
            addr_next  = s0_address[MEM_DEPTH_LOG2-1:0];
            count_next = bc_eff;
            state_next = RD_ISSUE;
            wait_next  = 1'b1;
          end
        end
      end
      WR_BURST: begin
        if (s0_read) err_next = 1'b1;
        if (s0_write) begin
          mem_we     = ~oor_q;
          addr_next  = addr_q + ADDR_ONE;
          count_next = count_q - BC_ONE;
          if (count_q == BC_ONE) state_next = IDLE;
        end
      end
      RD_ISSUE: begin
        issue      = 1'b1;
        addr_next  = addr_q + ADDR_ONE;
        count_next = count_q - BC_ONE;
        if (count_q == BC_ONE) state_next = IDLE;
        else wait_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      s0_waitrequest <= 1'b1;
      err_protocol   <= 1'b0;
      addr_q         <= '0;
      count_q        <= '0;
      oor_q          <= 1'b0;
    end else begin
      state          <= state_next;
      s0_waitrequest <= wait_next;
      err_protocol   <= err_next;
      addr_q         <= addr_next;
      count_q        <= count_next;
      oor_q          <= oor_next;
    end
  end

  // Array contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BYTEEN_WIDTH; i++) begin
        if (s0_byteenable[i])
          mem[mem_waddr][i*SYMBOL_WIDTH +: SYMBOL_WIDTH] <= s0_writedata[i*SYMBOL_WIDTH +: SYMBOL_WIDTH];
      end
    end
  end

  assign issue_data = oor_q ? '0 : mem[addr_q];

  // Issue happens the cycle after accept, so the pipe holds READ_LATENCY-1 stages
  if (READ_LATENCY == 1) begin : g_comb
    assign s0_readdatavalid = issue;
    assign s0_readdata      = issue_data;
    assign s0_response      = (issue & oor_q) ? RESP_SLVERR : '0;
  end else begin : g_pipe
    logic                  vld_q  [READ_LATENCY-1];
    logic                  err_q  [READ_LATENCY-1];
    logic [DATA_WIDTH-1:0] data_q [READ_LATENCY-1];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < READ_LATENCY-1; i++) begin
          vld_q[i]  <= 1'b0;
          err_q[i]  <= 1'b0;
          data_q[i] <= '0;
        end
      end else begin
        vld_q[0]  <= issue;
        err_q[0]  <= issue & oor_q;
        data_q[0] <= issue_data;
        for (int i = 1; i < READ_LATENCY-1; i++) begin
          vld_q[i]  <= vld_q[i-1];
          err_q[i]  <= err_q[i-1];
          data_q[i] <= data_q[i-1];
        end
      end
    end

    assign s0_readdatavalid = vld_q[READ_LATENCY-2];
    assign s0_readdata      = data_q[READ_LATENCY-2];
    assign s0_response      = err_q[READ_LATENCY-2] ? RESP_SLVERR : '0;
  end

endmodule

// File: tb/tb_avmm_mem_responder.sv
// Scoreboard bench for avmm_mem_responder: drivers push expected read beats,
// a negedge monitor pops and checks data, response and arrival cycle.
module tb_avmm_mem_responder;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s0_waitrequest;
  logic [9:0]  s0_address;
  logic [3:0]  s0_burstcount;
  logic        s0_read;
  logic        s0_write;
  logic [31:0] s0_writedata;
  logic [3:0]  s0_byteenable;
  logic [31:0] s0_readdata;
  logic        s0_readdatavalid;
  logic [1:0]  s0_response;
  logic        err_protocol;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   beats_seen = 0;

  avmm_mem_responder #(
    .DATA_WIDTH(32), .SYMBOL_WIDTH(8), .HDL_ADDR_WIDTH(10), .BURSTCOUNT_WIDTH(4),
    .RESPONSE_WIDTH(2), .MEM_DEPTH_LOG2(6), .READ_LATENCY(2), .BYTEEN_WIDTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .s0_waitrequest(s0_waitrequest),
    .s0_address(s0_address), .s0_burstcount(s0_burstcount), .s0_read(s0_read),
    .s0_write(s0_write), .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
    .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
    .s0_response(s0_response), .err_protocol(err_protocol)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid beat must match the oldest expectation, including its cycle
  always @(negedge clk) begin
    if (s0_readdatavalid) begin
      exp_t e;
      checks++;
      beats_seen++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_beat actual data=%08h resp=%0d cyc=%0d required none", s0_readdata, s0_response, cyc);
      end else begin
        e = sb.pop_front();
        if (s0_readdata !== e.data || s0_response !== e.resp || cyc != e.cyc) begin
          errors++;
          $display("[TB] FAIL read_beat actual data=%08h resp=%0d cyc=%0d required data=%08h resp=%0d cyc=%0d",
                   s0_readdata, s0_response, cyc, e.data, e.resp, e.cyc);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Entered at posedge+1 with a command driven; returns at posedge+1 after acceptance
  task automatic wait_accept(output int t);
    int guard = 0;
    @(negedge clk);
    while (s0_waitrequest && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (s0_waitrequest) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual=waitrequest stuck high required=accept");
    end
    t = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_read(input logic [9:0] addr, input logic [3:0] bc, input int n_beats,
                            input logic [31:0] exp0, input logic [31:0] inc,
                            input logic [1:0] resp, input int exp_wait);
    int t;
    int wc = 0;
    @(posedge clk);
    #1;
    s0_read       = 1'b1;
    s0_address    = addr;
    s0_burstcount = bc;
    wait_accept(t);
    s0_read = 1'b0;
    for (int k = 0; k < n_beats; k++) begin
      exp_t e;
      e.data = exp0 + k * inc;
      e.resp = resp;
      e.cyc  = t + 2 + k;
      sb.push_back(e);
    end
    @(negedge clk);
    while (s0_waitrequest && wc < 50) begin
      wc++;
      @(negedge clk);
    end
    check_output("read_waitrequest_cycles", wc, exp_wait);
  endtask

  task automatic apply_write(input logic [9:0] addr, input logic [3:0] bc, input int n_beats,
                             input logic [31:0] d0, input logic [31:0] inc, input logic [3:0] be,
                             input int gap_before, input logic also_read);
    int t;
    @(posedge clk);
    #1;
    s0_write      = 1'b1;
    s0_read       = also_read;
    s0_address    = addr;
    s0_burstcount = bc;
    s0_writedata  = d0;
    s0_byteenable = be;
    wait_accept(t);
    s0_read = 1'b0;
    for (int k = 1; k < n_beats; k++) begin
      if (k == gap_before) begin
        s0_write = 1'b0;
        @(posedge clk);
        #1;
      end
      s0_write     = 1'b1;
      s0_writedata = d0 + k * inc;
      @(posedge clk);
      #1;
    end
    s0_write = 1'b0;
  endtask

  task automatic reset_release;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_output("waitrequest_before_first_edge", s0_waitrequest, 1'b1);
    @(posedge clk);
    #1;
    check_output("waitrequest_after_first_edge", s0_waitrequest, 1'b0);
  endtask

  task automatic reset_pulse;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("reset_waitrequest", s0_waitrequest, 1'b1);
    check_output("reset_readdatavalid", s0_readdatavalid, 1'b0);
    check_output("reset_err_protocol", err_protocol, 1'b0);
    repeat (3) @(posedge clk);
    reset_release();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int guard;
    int target;
    reset_n = 1'b0;
    s0_read = 1'b0;
    s0_write = 1'b0;
    s0_address = '0;
    s0_burstcount = 4'd1;
    s0_writedata = '0;
    s0_byteenable = '0;
    #12;
    check_output("reset_waitrequest", s0_waitrequest, 1'b1);
    check_output("reset_readdatavalid", s0_readdatavalid, 1'b0);
    check_output("reset_response", s0_response, 2'b00);
    check_output("reset_err_protocol", err_protocol, 1'b0);
    reset_release();

    $display("[TB] single write then read");
    apply_write(10'h005, 4'd1, 1, 32'h12345678, 32'h0, 4'hF, -1, 1'b0);
    apply_read(10'h005, 4'd1, 1, 32'h12345678, 32'h0, 2'b00, 1);

    $display("[TB] partial-byte write burst with gap");
    apply_write(10'h010, 4'd4, 4, 32'hAAAAAAAA, 32'h0, 4'hF, -1, 1'b0);
    apply_write(10'h010, 4'd4, 4, 32'h55555555, 32'h0, 4'h3, 2, 1'b0);
    apply_read(10'h010, 4'd4, 4, 32'hAAAA5555, 32'h0, 2'b00, 4);

    $display("[TB] wrap and out-of-range");
    apply_write(10'h03E, 4'd4, 4, 32'hC0DE0000, 32'h1, 4'hF, -1, 1'b0);
    apply_read(10'h03E, 4'd4, 4, 32'hC0DE0000, 32'h1, 2'b00, 4);
    apply_read(10'h000, 4'd2, 2, 32'hC0DE0002, 32'h1, 2'b00, 2);
    apply_read(10'h040, 4'd2, 2, 32'h0, 32'h0, 2'b10, 2);
    apply_write(10'h040, 4'd1, 1, 32'hDEADBEEF, 32'h0, 4'hF, -1, 1'b0);
    apply_read(10'h000, 4'd1, 1, 32'hC0DE0002, 32'h0, 2'b00, 1);
    check_output("err_protocol_clean", err_protocol, 1'b0);

    $display("[TB] burstcount zero");
    apply_read(10'h005, 4'd0, 1, 32'h12345678, 32'h0, 2'b00, 1);
    check_output("err_protocol_bc0", err_protocol, 1'b1);
    reset_pulse();
    check_output("err_protocol_cleared", err_protocol, 1'b0);

    $display("[TB] read and write together");
    apply_write(10'h007, 4'd1, 1, 32'h0BADF00D, 32'h0, 4'hF, -1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check_output("err_protocol_rdwr", err_protocol, 1'b1);
    apply_read(10'h007, 4'd1, 1, 32'h0BADF00D, 32'h0, 2'b00, 1);

    $display("[TB] reset mid-burst");
    apply_write(10'h000, 4'd3, 3, 32'h00F00000, 32'h1, 4'hF, -1, 1'b0);
    @(posedge clk);
    #1;
    s0_read       = 1'b1;
    s0_address    = 10'h000;
    s0_burstcount = 4'd8;
    target        = beats_seen + 3;
    wait_accept(t);
    s0_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.data = 32'h00F00000 + k;
      e.resp = 2'b00;
      e.cyc  = t + 2 + k;
      sb.push_back(e);
    end
    guard = 0;
    while (beats_seen < target && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check_output("mid_burst_beats_seen", beats_seen, target);
    reset_n = 1'b0;
    #1;
    check_output("mid_burst_reset_valid", s0_readdatavalid, 1'b0);
    repeat (3) @(posedge clk);
    reset_release();
    apply_read(10'h000, 4'd1, 1, 32'h00F00000, 32'h0, 2'b00, 1);

    repeat (10) @(posedge clk);
    #1;
    check_output("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
